// File: rtl/axil_master_arbiter_if.sv
// AXI-Lite link bundle; the arbiter uses it for both requester ports and the interconnect port.
interface axil_master_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_master_arbiter.sv
// Two-requester AXI-Lite arbiter, one transaction in flight, granted channels pass through.
// Define AXIL_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module axil_master_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                         clk,
  input  logic                         rst,
  axil_master_arbiter_if.slave         s0_axil,
  axil_master_arbiter_if.slave         s1_axil,
  axil_master_arbiter_if.master        m_axil,
  output logic [1:0]                   grant,
  output logic                         busy
);
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;
  logic   aw_done, w_done, ar_done;

  // Requester ports flattened into arrays so the mux can index by grant.
  logic [NREQ-1:0]                 awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s;
  logic [NREQ-1:0][ADDR_WIDTH-1:0] awaddr_s, araddr_s;
  logic [NREQ-1:0][2:0]            awprot_s, arprot_s;
  logic [NREQ-1:0][DATA_WIDTH-1:0] wdata_s, rdata_s;
  logic [NREQ-1:0][STRB_WIDTH-1:0] wstrb_s;
  logic [NREQ-1:0]                 awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
  logic [NREQ-1:0][1:0]            bresp_s, rresp_s;

  assign awvalid_s = {s1_axil.awvalid, s0_axil.awvalid};
  assign awaddr_s  = {s1_axil.awaddr,  s0_axil.awaddr};
  assign awprot_s  = {s1_axil.awprot,  s0_axil.awprot};
  assign wvalid_s  = {s1_axil.wvalid,  s0_axil.wvalid};
  assign wdata_s   = {s1_axil.wdata,   s0_axil.wdata};
  assign wstrb_s   = {s1_axil.wstrb,   s0_axil.wstrb};
  assign bready_s  = {s1_axil.bready,  s0_axil.bready};
  assign arvalid_s = {s1_axil.arvalid, s0_axil.arvalid};
  assign araddr_s  = {s1_axil.araddr,  s0_axil.araddr};
  assign arprot_s  = {s1_axil.arprot,  s0_axil.arprot};
  assign rready_s  = {s1_axil.rready,  s0_axil.rready};

  assign s0_axil.awready = awready_s[0];
  assign s0_axil.wready  = wready_s[0];
  assign s0_axil.bvalid  = bvalid_s[0];
  assign s0_axil.bresp   = bresp_s[0];
  assign s0_axil.arready = arready_s[0];
  assign s0_axil.rvalid  = rvalid_s[0];
  assign s0_axil.rdata   = rdata_s[0];
  assign s0_axil.rresp   = rresp_s[0];
  assign s1_axil.awready = awready_s[1];
  assign s1_axil.wready  = wready_s[1];
  assign s1_axil.bvalid  = bvalid_s[1];
  assign s1_axil.bresp   = bresp_s[1];
  assign s1_axil.arready = arready_s[1];
  assign s1_axil.rvalid  = rvalid_s[1];
  assign s1_axil.rdata   = rdata_s[1];
  assign s1_axil.rresp   = rresp_s[1];

  logic sel, rd_act, wr_act;
  assign sel    = grant[1];
  assign rd_act = (state == READ);
  assign wr_act = (state == WRITE);

  // Done flags mask valid/ready so each address/data beat is passed exactly once.
  always_comb begin
    m_axil.awaddr  = wr_act ? awaddr_s[sel] : '0;
    m_axil.awprot  = wr_act ? awprot_s[sel] : '0;
    m_axil.awvalid = wr_act & awvalid_s[sel] & ~aw_done;
    m_axil.wdata   = wr_act ? wdata_s[sel] : '0;
    m_axil.wstrb   = wr_act ? wstrb_s[sel] : '0;
    m_axil.wvalid  = wr_act & wvalid_s[sel] & ~w_done;
    m_axil.bready  = wr_act & bready_s[sel];
    m_axil.araddr  = rd_act ? araddr_s[sel] : '0;
    m_axil.arprot  = rd_act ? arprot_s[sel] : '0;
    m_axil.arvalid = rd_act & arvalid_s[sel] & ~ar_done;
    m_axil.rready  = rd_act & rready_s[sel];

    awready_s = '0;
    wready_s  = '0;
    bvalid_s  = '0;
    bresp_s   = '0;
    arready_s = '0;
    rvalid_s  = '0;
    rdata_s   = '0;
    rresp_s   = '0;
    awready_s[sel] = wr_act & m_axil.awready & ~aw_done;
    wready_s[sel]  = wr_act & m_axil.wready & ~w_done;
    bvalid_s[sel]  = wr_act & m_axil.bvalid;
    bresp_s[sel]   = wr_act ? m_axil.bresp : 2'b00;
    arready_s[sel] = rd_act & m_axil.arready & ~ar_done;
    rvalid_s[sel]  = rd_act & m_axil.rvalid;
    rdata_s[sel]   = rd_act ? m_axil.rdata : '0;
    rresp_s[sel]   = rd_act ? m_axil.rresp : 2'b00;
  end

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = m_axil.awvalid & m_axil.awready;
  assign w_hs  = m_axil.wvalid  & m_axil.wready;
  assign b_hs  = m_axil.bvalid  & m_axil.bready;
  assign ar_hs = m_axil.arvalid & m_axil.arready;
  assign r_hs  = m_axil.rvalid  & m_axil.rready;

  logic [NREQ-1:0] req;
  logic            win;
  assign req = awvalid_s | arvalid_s;

`ifdef AXIL_ARB_RR_EN
  logic last;
  // On a tie the requester not granted last time wins.
  assign win = (&req) ? ~last : req[1];
`else
  assign win = (&req) ? 1'b0 : req[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
`ifdef AXIL_ARB_RR_EN
      last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= win ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            state <= awvalid_s[win] ? WRITE : READ;
`ifdef AXIL_ARB_RR_EN
            last  <= win;
`endif
          end
        end
        READ: begin
          if (ar_hs) ar_done <= 1'b1;
          if (r_hs) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            ar_done <= 1'b0;
          end
        end
        WRITE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if (b_hs) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
